// File: rtl/ps2_key_event.sv
// PS/2 frame receiver and scan-code decoder: 11-bit frames -> key events, held levels and flap pulse.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_event #(
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       ps2c_f,
  input  logic       ps2d_f,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err,
  output logic       space_held,
  output logic       up_held,
  output logic       flap_pulse
);

  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned FRAME_W = 11;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_UP    = 8'h75;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state;
  logic               ps2c_d;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] frame;
  logic [TO_W-1:0]    to_cnt;
  logic               ext_pend;
  logic               brk_pend;

  logic       ps2c_fall;
  logic       parity_ok;
  logic       frame_good;
  logic [7:0] rx_byte;
  logic       is_space;
  logic       is_up;

  // Frame layout after 11 LSB-first shifts: [0] start, [8:1] data, [9] parity, [10] stop.
  assign ps2c_fall  = ps2c_d & ~ps2c_f;
  assign rx_byte    = frame[8:1];
  assign parity_ok  = ^frame[9:1];
  assign frame_good = ~frame[0] & frame[10] & (parity_ok | ~PARITY_EN);
  assign is_space   = ~ext_pend & (rx_byte == CODE_SPACE);
  assign is_up      =  ext_pend & (rx_byte == CODE_UP);

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state      <= IDLE;
      ps2c_d     <= 1'b0;
      bit_cnt    <= '0;
      frame      <= '0;
      to_cnt     <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      key_code   <= '0;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
      space_held <= 1'b0;
      up_held    <= 1'b0;
      flap_pulse <= 1'b0;
    end else begin
      ps2c_d     <= ps2c_f;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
      flap_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (ps2c_fall && !ps2d_f) begin
            state   <= RECV;
            frame   <= {ps2d_f, frame[FRAME_W-1:1]};
            bit_cnt <= BIT_W'(1);
            to_cnt  <= '0;
          end
        end

        RECV: begin
          if (ps2c_fall) begin
            frame   <= {ps2d_f, frame[FRAME_W-1:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
            to_cnt  <= '0;
            if (bit_cnt == BIT_W'(FRAME_W - 1)) state <= CHECK;
          end else if (to_cnt == TO_LAST) begin
            // Stalled partial frame is dropped silently.
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        CHECK: begin
          state <= IDLE;
          if (!frame_good) begin
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end else if (rx_byte == CODE_EXT) begin
            ext_pend <= 1'b1;
          end else if (rx_byte == CODE_BRK) begin
            brk_pend <= 1'b1;
          end else begin
            key_code  <= rx_byte;
            key_ext   <= ext_pend;
            key_break <= brk_pend;
            key_valid <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            // Flap only on the first make, so typematic repeats stay silent.
            if (is_space) begin
              space_held <= ~brk_pend;
              if (!brk_pend && !space_held) flap_pulse <= 1'b1;
            end
            if (is_up) begin
              up_held <= ~brk_pend;
              if (!brk_pend && !up_held) flap_pulse <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// Self-checking bench for ps2_key_event: vector table, multi-cycle corner sequences, randomized frames vs model.
module tb_ps2_key_event;

  localparam int TO   = 25000;
  localparam int HALF = 4;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk_25 = 1'b0;
  logic       rst    = 1'b1;
  logic       ps2c_f = 1'b1;
  logic       ps2d_f = 1'b1;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid, frame_err, space_held, up_held, flap_pulse;

  ps2_key_event #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_25    (clk_25),
    .rst       (rst),
    .ps2c_f    (ps2c_f),
    .ps2d_f    (ps2d_f),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .frame_err (frame_err),
    .space_held(space_held),
    .up_held   (up_held),
    .flap_pulse(flap_pulse)
  );

  always #20 clk_25 = ~clk_25;

  int tests = 0;
  int fails = 0;

  // Strobe monitor, sampled on the inactive edge.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       flap;
  } ev_t;

  ev_t  ev_q[$];
  int   err_seen    = 0;
  int   wide_seen   = 0;
  int   orphan_seen = 0;
  logic prev_kv = 1'b0, prev_fe = 1'b0, prev_fl = 1'b0;

  always @(negedge clk_25) begin
    if (key_valid) ev_q.push_back(ev_t'({key_code, key_ext, key_break, flap_pulse}));
    if (frame_err) err_seen <= err_seen + 1;
    if ((key_valid && prev_kv) || (frame_err && prev_fe) || (flap_pulse && prev_fl))
      wide_seen <= wide_seen + 1;
    if (flap_pulse && !key_valid) orphan_seen <= orphan_seen + 1;
    prev_kv <= key_valid;
    prev_fe <= frame_err;
    prev_fl <= flap_pulse;
  end

  // Reference model state: decoded purely from the byte stream.
  bit       m_ext, m_brk, m_space, m_up, m_kext, m_kbrk;
  bit [7:0] m_code;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_space = 0; m_up = 0; m_kext = 0; m_kbrk = 0; m_code = 8'h00;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit pflip, input bit sbad);
    logic p;
    p = ~(^d) ^ pflip;
    return {~sbad, p, d, 1'b0};
  endfunction

  task automatic model_step(input logic [10:0] fr, output int ev, output int er, output bit fl);
    bit       good;
    bit [7:0] b;
    good = !fr[0] && fr[10] && (!PAR_EN || ($countones(fr[9:1]) % 2 == 1));
    b  = fr[8:1];
    ev = 0; er = 0; fl = 0;
    if (!good) begin
      er = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      ev = 1; m_code = b; m_kext = m_ext; m_kbrk = m_brk;
      if (b == 8'h29 && !m_ext) begin
        fl = !m_brk && !m_space; m_space = !m_brk;
      end
      if (b == 8'h75 && m_ext) begin
        fl = !m_brk && !m_up; m_up = !m_brk;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_25);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2d_f = b;
    tick(HALF);
    ps2c_f = 1'b0;
    tick(HALF);
    ps2c_f = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2_bit(fr[i]);
  endtask

  task automatic check_frame(input string nm, input int n, input int er, input int fl,
                             input int en, input int eer, input int efl, input int ecode,
                             input int eext, input int ebrk, input int esp, input int eup);
    check({nm, " valid"}, n, en);
    check({nm, " err"}, er, eer);
    check({nm, " flap"}, fl, efl);
    check({nm, " code"}, int'(key_code), ecode);
    check({nm, " ext"}, int'(key_ext), eext);
    check({nm, " brk"}, int'(key_break), ebrk);
    check({nm, " space"}, int'(space_held), esp);
    check({nm, " up"}, int'(up_held), eup);
  endtask

  task automatic check_zero(input string nm);
    check_frame(nm, int'(key_valid), int'(frame_err), int'(flap_pulse), 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Sends bits [lo..10] of fr (earlier bits already sent) and reports what the monitor saw.
  task automatic finish_frame(input logic [10:0] fr, input int lo, output int n, output int er, output int fl);
    int b_ev, b_er;
    b_ev = ev_q.size();
    b_er = err_seen;
    send_bits(fr, lo, 10);
    tick(6);
    n  = ev_q.size() - b_ev;
    er = err_seen - b_er;
    fl = (n > 0) ? int'(ev_q[b_ev].flap) : 0;
  endtask

  task automatic run_model(input string nm, input logic [10:0] fr, input int lo);
    int n, er, fl, en, eer;
    bit efl;
    finish_frame(fr, lo, n, er, fl);
    model_step(fr, en, eer, efl);
    check_frame(nm, n, er, fl, en, eer, int'(efl), int'(m_code), int'(m_kext), int'(m_kbrk),
                int'(m_space), int'(m_up));
  endtask

  typedef struct {
    logic [7:0] data;
    bit         pflip;
    bit         sbad;
    bit         valid;
    bit         err;
    bit         flap;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    bit         sp;
    bit         up;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int n, er, fl, dn, de;
    bit df;
    logic [10:0] fr;

    tbl[0]  = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{8'h29, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{8'h29, 1'b1, 1'b0, !PAR_EN, PAR_EN, 1'b0, 8'h29, !PAR_EN, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29, 1'b0, 1'b1, 1'b0, 1'b1};

    model_reset();
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(3);

    // Directed vectors; the model is stepped alongside to stay in sync.
    for (int i = 0; i < 19; i++) begin
      fr = make_frame(tbl[i].data, tbl[i].pflip, tbl[i].sbad);
      finish_frame(fr, 0, n, er, fl);
      model_step(fr, dn, de, df);
      check_frame($sformatf("tbl%0d", i), n, er, fl, int'(tbl[i].valid), int'(tbl[i].err),
                  int'(tbl[i].flap), int'(tbl[i].code), int'(tbl[i].ext), int'(tbl[i].brk),
                  int'(tbl[i].sp), int'(tbl[i].up));
    end

    // Strobe latency: two cycles after the final falling-edge sample, one cycle wide.
    fr = make_frame(8'h29, 1'b0, 1'b0);
    send_bits(fr, 0, 9);
    ps2d_f = fr[10];
    tick(HALF);
    ps2c_f = 1'b0;
    tick(1);
    check("lat n+1 valid", int'(key_valid), 0);
    tick(1);
    check("lat n+2 valid", int'(key_valid), 1);
    check("lat n+2 flap", int'(flap_pulse), 1);
    check("lat n+2 code", int'(key_code), 8'h29);
    tick(1);
    check("lat n+3 valid", int'(key_valid), 0);
    check("lat n+3 flap", int'(flap_pulse), 0);
    tick(HALF - 3);
    ps2c_f = 1'b1;
    tick(6);
    model_step(fr, dn, de, df);

    // A long but sub-timeout gap inside a frame must not drop it.
    fr = make_frame(8'h29, 1'b0, 1'b0);
    send_bits(fr, 0, 4);
    tick(TO - 1000);
    run_model("near_timeout", fr, 5);

    // A stalled partial F0 is discarded; the next frame decodes cleanly.
    fr = make_frame(8'hF0, 1'b0, 1'b0);
    send_bits(fr, 0, 4);
    tick(TO);
    fr = make_frame(8'h29, 1'b0, 1'b0);
    finish_frame(fr, 0, n, er, fl);
    model_step(fr, dn, de, df);
    check_frame("timeout", n, er, fl, 1, 0, 0, 8'h29, 0, 0, 1, int'(m_up));

    // Reset mid-frame with an E0 pending.
    run_model("pre_rst_e0", make_frame(8'hE0, 1'b0, 1'b0), 0);
    fr = make_frame(8'h75, 1'b0, 1'b0);
    send_bits(fr, 0, 4);
    rst = 1'b1;
    tick(2);
    check_zero("mid_rst");
    rst = 1'b0;
    model_reset();
    tick(3);
    finish_frame(fr, 0, n, er, fl);
    model_step(fr, dn, de, df);
    check_frame("post_rst", n, er, fl, 1, 0, 0, 8'h75, 0, 0, 0, 0);

    // Randomized byte stream, biased toward prefixes and the game keys.
    for (int i = 0; i < 80; i++) begin
      logic [7:0] d;
      case ($urandom_range(0, 5))
        0: d = 8'h29;
        1: d = 8'h75;
        2: d = 8'hE0;
        3: d = 8'hF0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      run_model($sformatf("rnd%0d", i),
                make_frame(d, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0), 0);
    end

    tick(4);
    check("strobe width", wide_seen, 0);
    check("flap w/o valid", orphan_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
